// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the ID->EX->MEM->WB control pipeline.
package ctrl_pkg;

    localparam int REG_AW_DEF  = 5;
    localparam int ALUOP_W_DEF = 2;
    localparam int CNT_W_DEF   = 16;

    typedef struct packed {
        logic valid;
        logic reg_write;
        logic mem_read;
        logic mem_to_reg;
        logic mem_write;
        logic alu_src;
        logic branch;
        logic jump;
    } ctrl_t;

    localparam ctrl_t BUBBLE = 8'h00;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    // The younger producer (MEM) always wins over the older one (WB).
    function automatic logic [1:0] fwd_pick(input logic mem_hit, input logic wb_hit);
        logic [1:0] sel;
        if (mem_hit) begin
            sel = FWD_MEM;
        end else if (wb_hit) begin
            sel = FWD_WB;
        end else begin
            sel = FWD_RF;
        end
        return sel;
    endfunction

endpackage

// File: rtl/ctrl_stage_reg.sv
// One pipeline stage register; reset or load_bubble loads the bubble pattern.
module ctrl_stage_reg #(
    parameter int           W          = 8,
    parameter logic [W-1:0] BUBBLE_VAL = {W{1'b0}}
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_bubble,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] data_d;
    logic [W-1:0] data_q;

    // Select between the incoming bundle and a bubble.
    always_comb begin
        if (load_bubble) begin
            data_d = BUBBLE_VAL;
        end else begin
            data_d = d;
        end
    end

    // Stage register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= BUBBLE_VAL;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/ctrl_pipeline.sv
// Control pipeline ID->EX->MEM->WB with load-use stall, branch/jump flush,
// ALU operand forwarding selects and saturating stall/flush counters.
module ctrl_pipeline
    import ctrl_pkg::*;
#(
    parameter int REG_AW  = REG_AW_DEF,
    parameter int ALUOP_W = ALUOP_W_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               id_valid,
    input  logic [REG_AW-1:0]  id_rs1,
    input  logic [REG_AW-1:0]  id_rs2,
    input  logic [REG_AW-1:0]  id_rd,
    input  logic               id_reg_write,
    input  logic               id_mem_read,
    input  logic               id_mem_to_reg,
    input  logic               id_mem_write,
    input  logic               id_alu_src,
    input  logic               id_branch,
    input  logic               id_jump,
    input  logic [ALUOP_W-1:0] id_alu_op,
    input  logic               ex_branch_taken,
    output logic               stall,
    output logic               flush,
    output logic [ALUOP_W-1:0] ex_alu_op,
    output logic               ex_alu_src,
    output logic               ex_branch,
    output logic               ex_jump,
    output logic [REG_AW-1:0]  ex_rs1,
    output logic [REG_AW-1:0]  ex_rs2,
    output logic               mem_mem_read,
    output logic               mem_mem_write,
    output logic [REG_AW-1:0]  mem_rd,
    output logic               wb_reg_write,
    output logic               wb_mem_to_reg,
    output logic [REG_AW-1:0]  wb_rd,
    output logic [1:0]         fwd_a,
    output logic [1:0]         fwd_b,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   flush_cnt
);

    localparam int IDEX_W  = 8 + ALUOP_W + 3 * REG_AW;
    localparam int EXMEM_W = 4 + REG_AW;
    localparam int MEMWB_W = 2 + REG_AW;
    localparam logic [REG_AW-1:0] X0      = {REG_AW{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [IDEX_W-1:0] IDEX_BUBBLE = {BUBBLE, {(ALUOP_W + 3 * REG_AW){1'b0}}};

    ctrl_t               id_ctrl_s;
    ctrl_t               ex_ctrl_s;
    logic [REG_AW-1:0]   ex_rd_s;
    logic [IDEX_W-1:0]   idex_d_s;
    logic [IDEX_W-1:0]   idex_q_s;
    logic [EXMEM_W-1:0]  exmem_d_s;
    logic [EXMEM_W-1:0]  exmem_q_s;
    logic [MEMWB_W-1:0]  memwb_q_s;
    logic                mem_reg_write_s;
    logic                mem_to_reg_s;
    logic                take_s;
    logic                luse_s;
    logic                stall_s;
    logic                idex_bubble_s;
    logic [CNT_W-1:0]    stall_cnt_d;
    logic [CNT_W-1:0]    stall_cnt_q;
    logic [CNT_W-1:0]    flush_cnt_d;
    logic [CNT_W-1:0]    flush_cnt_q;

    // mem_to_reg is undefined for stores/branches, so it is masked by reg_write.
    always_comb begin
        id_ctrl_s            = BUBBLE;
        id_ctrl_s.valid      = id_valid;
        id_ctrl_s.reg_write  = id_reg_write;
        id_ctrl_s.mem_read   = id_mem_read;
        id_ctrl_s.mem_to_reg = id_mem_to_reg & id_reg_write;
        id_ctrl_s.mem_write  = id_mem_write;
        id_ctrl_s.alu_src    = id_alu_src;
        id_ctrl_s.branch     = id_branch;
        id_ctrl_s.jump       = id_jump;
    end

    assign idex_d_s      = {id_ctrl_s, id_alu_op, id_rd, id_rs1, id_rs2};
    assign idex_bubble_s = take_s | stall_s | ~id_valid;

    ctrl_stage_reg #(
        .W          (IDEX_W),
        .BUBBLE_VAL (IDEX_BUBBLE)
    ) u_idex (
        .clk         (clk),
        .rst         (rst),
        .load_bubble (idex_bubble_s),
        .d           (idex_d_s),
        .q           (idex_q_s)
    );

    assign {ex_ctrl_s, ex_alu_op, ex_rd_s, ex_rs1, ex_rs2} = idex_q_s;
    assign ex_alu_src = ex_ctrl_s.alu_src;
    assign ex_branch  = ex_ctrl_s.branch;
    assign ex_jump    = ex_ctrl_s.jump;

    assign exmem_d_s = {ex_ctrl_s.reg_write, ex_ctrl_s.mem_read, ex_ctrl_s.mem_to_reg,
                        ex_ctrl_s.mem_write, ex_rd_s};

    ctrl_stage_reg #(
        .W (EXMEM_W)
    ) u_exmem (
        .clk         (clk),
        .rst         (rst),
        .load_bubble (1'b0),
        .d           (exmem_d_s),
        .q           (exmem_q_s)
    );

    assign {mem_reg_write_s, mem_mem_read, mem_to_reg_s, mem_mem_write, mem_rd} = exmem_q_s;

    ctrl_stage_reg #(
        .W (MEMWB_W)
    ) u_memwb (
        .clk         (clk),
        .rst         (rst),
        .load_bubble (1'b0),
        .d           ({mem_reg_write_s, mem_to_reg_s, mem_rd}),
        .q           (memwb_q_s)
    );

    assign {wb_reg_write, wb_mem_to_reg, wb_rd} = memwb_q_s;

    // A redirect kills the ID instruction, so it overrides a load-use stall.
    assign take_s  = ex_ctrl_s.valid & ((ex_ctrl_s.branch & ex_branch_taken) | ex_ctrl_s.jump);
    assign luse_s  = ex_ctrl_s.valid & ex_ctrl_s.mem_read & (ex_rd_s != X0) & id_valid
                   & ((ex_rd_s == id_rs1) | (ex_rd_s == id_rs2));
    assign stall_s = luse_s & ~take_s;
    assign stall   = stall_s;
    assign flush   = take_s;

    assign fwd_a = fwd_pick(mem_reg_write_s & (mem_rd != X0) & (mem_rd == ex_rs1),
                            wb_reg_write & (wb_rd != X0) & (wb_rd == ex_rs1));
    assign fwd_b = fwd_pick(mem_reg_write_s & (mem_rd != X0) & (mem_rd == ex_rs2),
                            wb_reg_write & (wb_rd != X0) & (wb_rd == ex_rs2));

    // Saturating increments for the event counters.
    always_comb begin
        if (stall_s && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
        if (take_s && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_d = flush_cnt_q + CNT_ONE;
        end else begin
            flush_cnt_d = flush_cnt_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= {CNT_W{1'b0}};
            flush_cnt_q <= {CNT_W{1'b0}};
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Directed bench for ctrl_pipeline: per-cycle comparison against an
// instruction-level pipeline model plus hand-computed checkpoints.
module tb_ctrl_pipeline;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       id_valid, id_reg_write, id_mem_read, id_mem_to_reg, id_mem_write;
    logic       id_alu_src, id_branch, id_jump, ex_branch_taken;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic [1:0] id_alu_op;

    logic        stall, flush, ex_alu_src, ex_branch, ex_jump;
    logic [1:0]  ex_alu_op, fwd_a, fwd_b;
    logic [4:0]  ex_rs1, ex_rs2, mem_rd, wb_rd;
    logic        mem_mem_read, mem_mem_write, wb_reg_write, wb_mem_to_reg;
    logic [15:0] stall_cnt, flush_cnt;

    logic        d2_stall, d2_flush, d2_ex_alu_src, d2_ex_branch, d2_ex_jump;
    logic [1:0]  d2_ex_alu_op, d2_fwd_a, d2_fwd_b;
    logic [4:0]  d2_ex_rs1, d2_ex_rs2, d2_mem_rd, d2_wb_rd;
    logic        d2_mem_mem_read, d2_mem_mem_write, d2_wb_reg_write, d2_wb_mem_to_reg;
    logic [1:0]  d2_stall_cnt, d2_flush_cnt;

    ctrl_pipeline #(.REG_AW(5), .ALUOP_W(2), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_to_reg(id_mem_to_reg), .id_mem_write(id_mem_write), .id_alu_src(id_alu_src),
        .id_branch(id_branch), .id_jump(id_jump), .id_alu_op(id_alu_op),
        .ex_branch_taken(ex_branch_taken), .stall(stall), .flush(flush),
        .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src), .ex_branch(ex_branch),
        .ex_jump(ex_jump), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .mem_mem_read(mem_mem_read),
        .mem_mem_write(mem_mem_write), .mem_rd(mem_rd), .wb_reg_write(wb_reg_write),
        .wb_mem_to_reg(wb_mem_to_reg), .wb_rd(wb_rd), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    ctrl_pipeline #(.REG_AW(5), .ALUOP_W(2), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_to_reg(id_mem_to_reg), .id_mem_write(id_mem_write), .id_alu_src(id_alu_src),
        .id_branch(id_branch), .id_jump(id_jump), .id_alu_op(id_alu_op),
        .ex_branch_taken(ex_branch_taken), .stall(d2_stall), .flush(d2_flush),
        .ex_alu_op(d2_ex_alu_op), .ex_alu_src(d2_ex_alu_src), .ex_branch(d2_ex_branch),
        .ex_jump(d2_ex_jump), .ex_rs1(d2_ex_rs1), .ex_rs2(d2_ex_rs2),
        .mem_mem_read(d2_mem_mem_read), .mem_mem_write(d2_mem_mem_write), .mem_rd(d2_mem_rd),
        .wb_reg_write(d2_wb_reg_write), .wb_mem_to_reg(d2_wb_mem_to_reg), .wb_rd(d2_wb_rd),
        .fwd_a(d2_fwd_a), .fwd_b(d2_fwd_b), .stall_cnt(d2_stall_cnt), .flush_cnt(d2_flush_cnt)
    );

    // ---------------- instruction-level model ----------------
    typedef struct packed {
        logic       valid, rw, mr, m2r, mw, as, br, jp;
        logic [1:0] op;
        logic [4:0] rd, rs1, rs2;
    } instr_t;

    instr_t      m_ex = '0, m_mem = '0, m_wb = '0;
    int unsigned n_stall = 0, n_flush = 0;
    int          checks = 0, failures = 0;
    logic        chk_en = 1'b0;

    function automatic logic m_take();
        return m_ex.valid && ((m_ex.br && ex_branch_taken) || m_ex.jp);
    endfunction

    function automatic logic m_stall();
        logic luse;
        luse = m_ex.valid && m_ex.mr && (m_ex.rd != 5'd0) && id_valid &&
               ((m_ex.rd == id_rs1) || (m_ex.rd == id_rs2));
        return luse && !m_take();
    endfunction

    function automatic logic [1:0] m_fwd(input logic [4:0] rs);
        if (rs == 5'd0) return 2'b00;
        if (m_mem.rw && (m_mem.rd == rs)) return 2'b10;
        if (m_wb.rw && (m_wb.rd == rs)) return 2'b01;
        return 2'b00;
    endfunction

    function automatic int unsigned sat(input int unsigned n, input int w);
        int unsigned mx;
        mx = (32'd1 << w) - 32'd1;
        return (n > mx) ? mx : n;
    endfunction

    function automatic instr_t id_now();
        instr_t t;
        t = '{id_valid, id_reg_write, id_mem_read, id_mem_to_reg & id_reg_write, id_mem_write,
              id_alu_src, id_branch, id_jump, id_alu_op, id_rd, id_rs1, id_rs2};
        return t;
    endfunction

    function automatic logic [34:0] exp_vec();
        return {m_ex.op, m_ex.as, m_ex.br, m_ex.jp, m_ex.rs1, m_ex.rs2, m_mem.mr, m_mem.mw,
                m_mem.rd, m_wb.rw, m_wb.m2r, m_wb.rd, m_stall(), m_take(),
                m_fwd(m_ex.rs1), m_fwd(m_ex.rs2)};
    endfunction

    // Model advances one stage per clock.
    always @(posedge clk) begin
        if (rst) begin
            m_ex <= '0; m_mem <= '0; m_wb <= '0; n_stall <= 0; n_flush <= 0;
        end else begin
            m_wb  <= m_mem;
            m_mem <= m_ex;
            m_ex  <= (m_take() || m_stall() || !id_valid) ? instr_t'(0) : id_now();
            if (m_stall()) n_stall <= n_stall + 1;
            if (m_take())  n_flush <= n_flush + 1;
        end
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("ex_alu_op", ex_alu_op, m_ex.op);
            check("ex_alu_src", ex_alu_src, m_ex.as);
            check("ex_branch", ex_branch, m_ex.br);
            check("ex_jump", ex_jump, m_ex.jp);
            check("ex_rs1", ex_rs1, m_ex.rs1);
            check("ex_rs2", ex_rs2, m_ex.rs2);
            check("mem_mem_read", mem_mem_read, m_mem.mr);
            check("mem_mem_write", mem_mem_write, m_mem.mw);
            check("mem_rd", mem_rd, m_mem.rd);
            check("wb_reg_write", wb_reg_write, m_wb.rw);
            check("wb_mem_to_reg", wb_mem_to_reg, m_wb.m2r);
            check("wb_rd", wb_rd, m_wb.rd);
            check("stall", stall, m_stall());
            check("flush", flush, m_take());
            check("fwd_a", fwd_a, m_fwd(m_ex.rs1));
            check("fwd_b", fwd_b, m_fwd(m_ex.rs2));
            check("stall_cnt", stall_cnt, sat(n_stall, 16));
            check("flush_cnt", flush_cnt, sat(n_flush, 16));
            check("d2_pipe", {d2_ex_alu_op, d2_ex_alu_src, d2_ex_branch, d2_ex_jump, d2_ex_rs1,
                              d2_ex_rs2, d2_mem_mem_read, d2_mem_mem_write, d2_mem_rd,
                              d2_wb_reg_write, d2_wb_mem_to_reg, d2_wb_rd, d2_stall, d2_flush,
                              d2_fwd_a, d2_fwd_b}, exp_vec());
            check("d2_stall_cnt", d2_stall_cnt, sat(n_stall, 2));
            check("d2_flush_cnt", d2_flush_cnt, sat(n_flush, 2));
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_id(input logic v, rw, mr, m2r, mw, as, br, jp,
                          input logic [1:0] op, input logic [4:0] rd, rs1, rs2);
        id_valid = v; id_reg_write = rw; id_mem_read = mr; id_mem_to_reg = m2r;
        id_mem_write = mw; id_alu_src = as; id_branch = br; id_jump = jp;
        id_alu_op = op; id_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
    endtask

    task automatic nop();
        set_id(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 5'd0, 5'd0, 5'd0);
    endtask

    task automatic lw(input logic [4:0] rd, input logic [4:0] rs1);
        set_id(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, rd, rs1, 5'd0);
    endtask

    task automatic add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        set_id(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, rd, rs1, rs2);
    endtask

    task automatic to_pos();
        @(posedge clk);
        #1;
    endtask

    task automatic to_neg();
        @(negedge clk);
    endtask

    initial begin
        // Reset with every ID input high.
        rst = 1'b1; ex_branch_taken = 1'b1;
        set_id(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'd3, 5'd31, 5'd31, 5'd31);
        to_pos();
        chk_en = 1'b1;
        to_pos();
        to_neg();
        check("rst_ex_alu_op", ex_alu_op, 2'd0);
        check("rst_ex_jump", ex_jump, 1'b0);
        check("rst_ex_rs1", ex_rs1, 5'd0);
        check("rst_mem_rd", mem_rd, 5'd0);
        check("rst_wb_rd", wb_rd, 5'd0);
        check("rst_stall", stall, 1'b0);
        check("rst_flush", flush, 1'b0);
        check("rst_fwd_a", fwd_a, 2'b00);
        check("rst_stall_cnt", stall_cnt, 16'd0);
        to_pos();
        rst = 1'b0; ex_branch_taken = 1'b0; nop();
        to_pos();

        // Load-use: one stall, bubble, then operand comes from the load in WB.
        lw(5'd5, 5'd2);
        to_pos();
        add(5'd7, 5'd5, 5'd6);
        to_neg();
        check("lu_stall", stall, 1'b1);
        to_pos();
        to_neg();
        check("lu_stall_drop", stall, 1'b0);
        check("lu_ex_bubble", ex_rs1, 5'd0);
        check("lu_mem_rd", mem_rd, 5'd5);
        check("lu_stall_cnt", stall_cnt, 16'd1);
        to_pos();
        nop();
        to_neg();
        check("lu_ex_rs1", ex_rs1, 5'd5);
        check("lu_fwd_a", fwd_a, 2'b01);
        check("lu_wb_m2r", wb_mem_to_reg, 1'b1);
        to_pos(); to_pos();

        // Forwarding priority: MEM over WB.
        add(5'd3, 5'd1, 5'd2); to_pos();
        add(5'd3, 5'd1, 5'd2); to_pos();
        add(5'd4, 5'd3, 5'd3); to_pos();
        nop();
        to_neg();
        check("fw_a_mem", fwd_a, 2'b10);
        check("fw_b_mem", fwd_b, 2'b10);
        to_pos();

        // MEM producer without reg_write falls back to WB; store's mem_to_reg is masked.
        add(5'd3, 5'd1, 5'd2); to_pos();
        set_id(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 5'd3, 5'd1, 5'd2); to_pos();
        add(5'd4, 5'd9, 5'd3); to_pos();
        nop();
        to_neg();
        check("fw_b_wb", fwd_b, 2'b01);
        check("fw_a_none", fwd_a, 2'b00);
        to_pos();
        to_neg();
        check("st_wb_rd", wb_rd, 5'd3);
        check("st_wb_m2r", wb_mem_to_reg, 1'b0);
        to_pos();

        // x0 is never forwarded nor a load-use source.
        add(5'd0, 5'd1, 5'd2); to_pos();
        add(5'd0, 5'd1, 5'd2); to_pos();
        add(5'd4, 5'd0, 5'd0); to_pos();
        nop();
        to_neg();
        check("fw_x0_b", fwd_b, 2'b00);
        to_pos();
        lw(5'd0, 5'd1); to_pos();
        add(5'd6, 5'd0, 5'd0);
        to_neg();
        check("lu_x0_stall", stall, 1'b0);
        to_pos();
        nop(); to_pos(); to_pos();

        // Taken branch in EX beats a load-use in ID.
        set_id(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 5'd8, 5'd1, 5'd2);
        to_pos();
        add(5'd9, 5'd8, 5'd0); ex_branch_taken = 1'b1;
        to_neg();
        check("br_flush", flush, 1'b1);
        check("br_stall", stall, 1'b0);
        to_pos();
        nop(); ex_branch_taken = 1'b0;
        to_neg();
        check("br_ex_bubble", ex_rs1, 5'd0);
        check("br_flush_cnt", flush_cnt, 16'd1);
        to_pos();

        // Same branch not taken: no flush, the load-use stalls.
        set_id(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 5'd8, 5'd1, 5'd2);
        to_pos();
        add(5'd9, 5'd8, 5'd0);
        to_neg();
        check("nt_flush", flush, 1'b0);
        check("nt_stall", stall, 1'b1);
        to_pos();
        to_pos();
        nop(); to_pos();

        // Jump flushes regardless of ex_branch_taken.
        set_id(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 5'd1, 5'd0, 5'd0);
        to_pos();
        add(5'd2, 5'd1, 5'd0);
        to_neg();
        check("jmp_flush", flush, 1'b1);
        to_pos();
        nop();
        to_neg();
        check("jmp_flush_cnt", flush_cnt, 16'd2);
        to_pos();

        // Five more load-use stalls: 7 in total, the 2-bit counter holds at 3.
        for (int i = 0; i < 5; i++) begin
            lw(5'd5, 5'd1); to_pos();
            add(5'd6, 5'd5, 5'd0); to_pos();
            to_pos();
        end
        nop(); to_pos();
        to_neg();
        check("sat_cnt2", d2_stall_cnt, 2'd3);
        check("sat_cnt16", stall_cnt, 16'd7);
        to_pos();

        // Reset during a stall cycle.
        lw(5'd5, 5'd1); to_pos();
        add(5'd6, 5'd5, 5'd0); rst = 1'b1;
        to_neg();
        check("rs_stall_before", stall, 1'b1);
        to_pos();
        rst = 1'b0; nop();
        to_neg();
        check("rs_stall", stall, 1'b0);
        check("rs_mem_rd", mem_rd, 5'd0);
        check("rs_mem_read", mem_mem_read, 1'b0);
        check("rs_stall_cnt", stall_cnt, 16'd0);
        to_pos(); to_pos();

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
